// File: rtl/pe_cube_pkg.sv
// pe_cube_pkg: definitions shared by the PE cube and its operand feeder.
//   feeder_state_e : pass sequencer states
//   DEF_DATA_W     : default operand width
//   lane_idx()     : (array i, block j) -> flat lane index, so producer and
//                    consumer of the packed oData/iData bus agree on order
package pe_cube_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_e;

    localparam int DEF_DATA_W = 8;

    function automatic int lane_idx(input int i, input int j, input int array_num);
        return j * array_num + i;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: fixed-depth shift register for one array's operand row
// plus its valid bit. Resets to zero; DEPTH = 0 degenerates to a wire.
//   iClk, iRst     : clock, async active-high reset
//   iData, iValid  : row entering the line
//   oData, oValid  : row delayed by DEPTH cycles
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    input  logic             iValid,
    output logic [WIDTH-1:0] oData,
    output logic             oValid
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = iClk | iRst;
            assign oData  = iData;
            assign oValid = iValid;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] data_pipe;
            logic [DEPTH-1:0]            vld_pipe;

            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    data_pipe <= '0;
                    vld_pipe  <= '0;
                end else begin
                    data_pipe[0] <= iData;
                    vld_pipe[0]  <= iValid;
                    for (int k = 1; k < DEPTH; k++) begin
                        data_pipe[k] <= data_pipe[k-1];
                        vld_pipe[k]  <= vld_pipe[k-1];
                    end
                end
            end

            assign oData  = data_pipe[DEPTH-1];
            assign oValid = vld_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pe_cube_feeder.sv
// pe_cube_feeder: operand feeder for one PE cube. Per pass: clear the
// accumulators, stream iLen accepted beats through a per-(array, block)
// data1/data2 select, then skew array i by i cycles for the systolic
// diagonal and pulse oDone when the last array shows its final beat.
//   iClk, iRst            : clock, async active-high reset
//   iStart, iLen, iSelMask: pass control, latched in IDLE on iStart
//   iValid / oReady       : beat handshake (unaccepted beats are dropped)
//   iData1, iData2        : operand rows, lane i = array i
//   oData, oValid         : skewed operands, lane j*ARRAY_NUM+i; per-array valid
//   oClearAcc, oBusy, oDone: pass status (all registered)
module pe_cube_feeder
    import pe_cube_pkg::*;
#(
    parameter int ARRAY_NUM = 3,
    parameter int BLOCK_NUM = 3,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_W     = 8
) (
    input  logic                                iClk,
    input  logic                                iRst,
    input  logic                                iStart,
    input  logic [LEN_W-1:0]                    iLen,
    input  logic [ARRAY_NUM*BLOCK_NUM-1:0]      iSelMask,
    input  logic                                iValid,
    output logic                                oReady,
    input  logic [DATA_W*ARRAY_NUM-1:0]         iData1,
    input  logic [DATA_W*ARRAY_NUM-1:0]         iData2,
    output logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] oData,
    output logic [ARRAY_NUM-1:0]                oValid,
    output logic                                oClearAcc,
    output logic                                oBusy,
    output logic                                oDone
);

    // DRAIN lasts ARRAY_NUM-1 cycles; the counter reaching DRAIN_LAST marks its final one.
    localparam int DRAIN_LAST = (ARRAY_NUM > 1) ? ARRAY_NUM - 2 : 0;
    localparam int DRN_W      = (ARRAY_NUM > 2) ? $clog2(ARRAY_NUM - 1) : 1;

    feeder_state_e state_q, state_d;

    logic [LEN_W-1:0]               len_q;
    logic [LEN_W-1:0]               beat_cnt;
    logic [ARRAY_NUM*BLOCK_NUM-1:0] mask_q;
    logic [DRN_W-1:0]               drain_cnt;

    logic accept;
    logic last_beat;

    // oReady is high exactly in STREAM, so it doubles as the state qualifier here.
    assign accept    = iValid & oReady;
    // beat_cnt never exceeds len_q-1 in STREAM, so the +1 cannot wrap.
    assign last_beat = accept && ((beat_cnt + LEN_W'(1)) == len_q);

    // ---------------- FSM ----------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (iStart) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = (len_q != '0) ? ST_STREAM : ST_DONE;
            ST_STREAM: if (last_beat) state_d = (ARRAY_NUM == 1) ? ST_DONE : ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == DRN_W'(DRAIN_LAST)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered off the next state so they line up with it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oReady    <= 1'b0;
            oClearAcc <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            len_q     <= '0;
            mask_q    <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            oReady    <= (state_d == ST_STREAM);
            oClearAcc <= (state_d == ST_CLEAR);
            oBusy     <= (state_d != ST_IDLE);
            oDone     <= (state_d == ST_DONE);

            if (state_q == ST_IDLE && iStart) begin
                len_q    <= iLen;
                mask_q   <= iSelMask;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end

            drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + DRN_W'(1) : '0;
        end
    end

    // ---------------- select + stage 0 ----------------
    logic [ARRAY_NUM-1:0][BLOCK_NUM-1:0][DATA_W-1:0] row_d, row_q, row_out;
    logic [ARRAY_NUM-1:0]                            vld_q;

    // Bubbles (no accepted beat) enter as zero data with valid low.
    always_comb begin
        row_d = '0;
        for (int i = 0; i < ARRAY_NUM; i++) begin
            for (int j = 0; j < BLOCK_NUM; j++) begin
                if (accept) begin
                    row_d[i][j] = mask_q[BLOCK_NUM*i + j] ? iData2[i*DATA_W +: DATA_W]
                                                          : iData1[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            row_q <= '0;
            vld_q <= '0;
        end else begin
            row_q <= row_d;
            vld_q <= {ARRAY_NUM{accept}};
        end
    end

    // ---------------- skew ----------------
    generate
        for (genvar i = 0; i < ARRAY_NUM; i++) begin : g_arr
            skew_delay_line #(
                .DEPTH (i),
                .WIDTH (BLOCK_NUM*DATA_W)
            ) u_skew (
                .iClk   (iClk),
                .iRst   (iRst),
                .iData  (row_q[i]),
                .iValid (vld_q[i]),
                .oData  (row_out[i]),
                .oValid (oValid[i])
            );
        end
    endgenerate

    always_comb begin
        oData = '0;
        for (int i = 0; i < ARRAY_NUM; i++) begin
            for (int j = 0; j < BLOCK_NUM; j++) begin
                oData[lane_idx(i, j, ARRAY_NUM)*DATA_W +: DATA_W] = row_out[i][j];
            end
        end
    end

endmodule

// File: tb/tb_pe_cube_feeder.sv
// tb_pe_cube_feeder: directed scenarios plus randomized traffic, checked
// every cycle against a timeline model built from the pass timing rules
// (clear at t+1, ready from t+2, beat at a -> array i at a+1+i, done at L+A).
module tb_pe_cube_feeder;

    localparam int A  = 3;
    localparam int B  = 3;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int NC = 4096;
    localparam int BIG = 32'h3fff_ffff;

    logic               clk;
    logic               iRst;
    logic               iStart;
    logic [LW-1:0]      iLen;
    logic [A*B-1:0]     iSelMask;
    logic               iValid;
    logic               oReady;
    logic [A*DW-1:0]    iData1, iData2;
    logic [A*B*DW-1:0]  oData;
    logic [A-1:0]       oValid;
    logic               oClearAcc, oBusy, oDone;

    pe_cube_feeder #(.ARRAY_NUM(A), .BLOCK_NUM(B), .DATA_W(DW), .LEN_W(LW)) dut (
        .iClk(clk), .iRst(iRst), .iStart(iStart), .iLen(iLen), .iSelMask(iSelMask),
        .iValid(iValid), .oReady(oReady), .iData1(iData1), .iData2(iData2),
        .oData(oData), .oValid(oValid), .oClearAcc(oClearAcc), .oBusy(oBusy), .oDone(oDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Expected timeline, indexed by cycle number.
    bit [DW-1:0] exp_lane [NC][A*B];
    bit          exp_vld  [NC][A];
    bit          exp_clr  [NC];
    bit          exp_done [NC];

    // Pass bookkeeping.
    bit          m_live = 0;
    bit          m_closed = 0;
    int          m_t = 0;
    int          m_busy_end = 0;
    int          m_len = 0;
    int          m_beats = 0;
    logic [A*B-1:0] m_mask = '0;

    logic [LW-1:0]  cur_len = '0;
    logic [A*B-1:0] cur_mask = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},  128'(oReady),    128'(0));
        chk({tag, "_clr"},  128'(oClearAcc), 128'(0));
        chk({tag, "_busy"}, 128'(oBusy),     128'(0));
        chk({tag, "_done"}, 128'(oDone),     128'(0));
        chk({tag, "_vld"},  128'(oValid),    128'(0));
        chk({tag, "_data"}, 128'(oData),     128'(0));
    endtask

    function automatic bit m_idle(input int c);
        return !m_live || (c >= m_busy_end);
    endfunction

    // One clock: check cycle cyc's outputs, then drive its inputs and extend the timeline.
    task automatic tick(input logic rs, input logic st, input logic vl,
                        input logic [A*DW-1:0] d1, input logic [A*DW-1:0] d2);
        logic [A*B*DW-1:0] ed;
        logic [A-1:0]      ev;
        logic              er, eb;
        @(posedge clk);
        #1;
        cyc++;
        ed = '0;
        ev = '0;
        for (int k = 0; k < A*B; k++) ed[k*DW +: DW] = exp_lane[cyc][k];
        for (int i = 0; i < A; i++) ev[i] = exp_vld[cyc][i];
        er = m_live && !m_closed && (cyc >= m_t + 2);
        eb = m_live && (cyc > m_t) && (cyc < m_busy_end);
        chk("ready", 128'(oReady),    128'(er));
        chk("busy",  128'(oBusy),     128'(eb));
        chk("clear", 128'(oClearAcc), 128'(exp_clr[cyc]));
        chk("done",  128'(oDone),     128'(exp_done[cyc]));
        chk("valid", 128'(oValid),    128'(ev));
        chk("data",  128'(oData),     128'(ed));

        iRst = rs; iStart = st; iLen = cur_len; iSelMask = cur_mask;
        iValid = vl; iData1 = d1; iData2 = d2;

        if (!rs) begin
            if (er && vl) begin
                for (int i = 0; i < A; i++) begin
                    exp_vld[cyc+1+i][i] = 1'b1;
                    for (int j = 0; j < B; j++)
                        exp_lane[cyc+1+i][j*A+i] = m_mask[B*i+j] ? d2[i*DW +: DW] : d1[i*DW +: DW];
                end
                m_beats++;
                if (m_beats == m_len) begin
                    m_closed = 1;
                    exp_done[cyc+A] = 1;
                    m_busy_end = cyc + A + 1;
                end
            end
            if (st && m_idle(cyc)) begin
                m_live = 1; m_t = cyc; m_len = int'(cur_len); m_mask = cur_mask; m_beats = 0;
                exp_clr[cyc+1] = 1;
                if (cur_len == '0) begin
                    m_closed = 1;
                    exp_done[cyc+2] = 1;
                    m_busy_end = cyc + 3;
                end else begin
                    m_closed = 0;
                    m_busy_end = BIG;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, '0, '0);
    endtask

    task automatic go(input logic [LW-1:0] ln, input logic [A*B-1:0] mk);
        if (m_idle(cyc + 1)) begin
            cur_len = ln;
            cur_mask = mk;
        end
        tick(0, 1, 0, '0, '0);
    endtask

    task automatic beat(input logic [A*DW-1:0] d1, input logic [A*DW-1:0] d2);
        tick(0, 0, 1, d1, d2);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before the next edge.
    task automatic async_rst();
        #2;
        iRst = 1'b1;
        #1;
        chk_zero("arst");
        for (int k = cyc + 1; k < NC; k++) begin
            exp_clr[k] = 0;
            exp_done[k] = 0;
            for (int i = 0; i < A; i++) exp_vld[k][i] = 0;
            for (int l = 0; l < A*B; l++) exp_lane[k][l] = '0;
        end
        m_live = 0;
        m_busy_end = 0;
        tick(1, 0, 0, '0, '0);
        tick(0, 0, 0, '0, '0);
    endtask

    initial begin
        iRst = 1'b1; iStart = 0; iLen = '0; iSelMask = '0; iValid = 0;
        iData1 = '0; iData2 = '0;
        #2;
        chk_zero("por");
        tick(1, 0, 0, '0, '0);
        tick(1, 0, 0, '0, '0);
        tick(0, 0, 0, '0, '0);
        idle(2);

        // basic pass, mask 0
        go(8'd2, '0);
        idle(1);
        beat(24'h030201, 24'hAAAAAA);
        beat(24'h060504, 24'hBBBBBB);
        idle(5);

        // mask coverage
        go(8'd1, 9'b110_110_110);
        idle(1);
        beat(24'h111111, 24'h222222);
        idle(4);
        go(8'd1, 9'h1FF);
        idle(1);
        beat(24'h111111, 24'h222222);
        idle(4);

        // bubble mid-pass
        go(8'd3, 9'b001_010_100);
        idle(1);
        beat(24'h0A0B0C, 24'hC0B0A0);
        tick(0, 0, 0, 24'hFFFFFF, 24'hFFFFFF);
        beat(24'h1A1B1C, 24'hC1B1A1);
        beat(24'h2A2B2C, 24'hC2B2A2);
        idle(5);

        // empty pass
        go(8'd0, 9'h155);
        idle(4);

        // reset during STREAM, then a clean pass
        go(8'd4, 9'h0F0);
        idle(1);
        beat(24'h123456, 24'h654321);
        beat(24'h777777, 24'h888888);
        async_rst();
        idle(2);
        go(8'd2, 9'h0AA);
        idle(1);
        beat(24'h313233, 24'h414243);
        beat(24'h515253, 24'h616263);
        // start pulsed during DRAIN and DONE: ignored
        tick(0, 1, 0, '0, '0);
        tick(0, 1, 0, '0, '0);
        tick(0, 1, 0, '0, '0);
        idle(4);

        // full-range length
        go(8'd255, 9'(($urandom)));
        idle(1);
        repeat (255) beat(24'($urandom), 24'($urandom));
        idle(5);

        // randomized traffic
        while (cyc < 3600) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) async_rst();
            else if (r < 14) go(8'($urandom_range(0, 6)), 9'($urandom));
            else tick(0, 0, ($urandom_range(0, 9) < 7), 24'($urandom), 24'($urandom));
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_cube_feeder.md
# pe_cube_feeder

Parametrised operand feeder for the PE cube. It generalises the fixed five-pattern input mux to an arbitrary per-(array, block) data1/data2 select mask and adds a pass sequencer: accumulator clear, a counted valid/ready stream and systolic row skew. It sits between the operand buffers and the cube's `iData` / `iClearAcc` inputs, one instance per cube.

## Interface
- `ARRAY_NUM`, 3, number of PE arrays (rows) per block.
- `BLOCK_NUM`, 3, number of blocks fed per array.
- `DATA_W`, 8, operand width.
- `LEN_W`, 8, width of the beat counter.

- `iClk`  in  1  clock.
- `iRst`  in  1  reset; **asynchronous, active-high**.
- `iStart`  in  1  start a pass; sampled only in IDLE.
- `iLen`  in  LEN_W  beats in the pass; latched on start.
- `iSelMask`  in  ARRAY_NUM*BLOCK_NUM  bit `[BLOCK_NUM*i+j]`: 1 selects iData2, 0 selects iData1 for array i, block j; latched on start.
- `iValid`  in  1  input beat valid.
- `oReady`  out  1  feeder accepts a beat.
- `iData1`, `iData2`  in  DATA_W*ARRAY_NUM  operand rows; lane i = array i.
- `oData`  out  DATA_W*ARRAY_NUM*BLOCK_NUM  lane `(j*ARRAY_NUM+i)` = array i, block j.
- `oValid`  out  ARRAY_NUM  per-array beat valid, after skew.
- `oClearAcc`  out  1  one-cycle accumulator clear.
- `oBusy`  out  1  high in every state except IDLE.
- `oDone`  out  1  one-cycle end-of-pass pulse.

## Operation
- FSM states and transitions:
  - IDLE → CLEAR on `iStart`.
  - CLEAR → STREAM if the latched `iLen` ≠ 0, else → DONE.
  - STREAM → DRAIN after the iLen-th accepted beat. If ARRAY_NUM = 1, STREAM → DONE instead.
  - DRAIN → DONE after ARRAY_NUM−1 cycles.
  - DONE → IDLE unconditionally.
- Handshake:
  - A beat is accepted when `iValid & oReady`.
  - `oReady` = (state == STREAM) and registered.
  - `iValid` without `oReady` is dropped, not queued.
- Select: a mask-selected row enters stage 0 as `{BLOCK_NUM copies}` per array. For each block j, the lane takes `iData2[i]` if its mask bit is 1, else `iData1[i]`.
- Bubble: a STREAM cycle without an accepted beat injects zeros with valid 0. It does not count toward `iLen`.
- Skew: array i passes through i extra register stages, forming the systolic diagonal. Stages always shift; there is no downstream back-pressure.
- Flag reset values: `iStart` while busy is ignored. Mask and length are stable for the whole pass.
- Reset (asynchronous, at any time, including mid-pass) sets:
  - state to IDLE;
  - the counter, mask and all skew registers to 0;
  - all outputs to 0.
- Width rule: `iLen` is an unsigned count from 0 to 2^LEN_W−1. The counter compares equal and does not wrap.

## Timing
- All outputs are registered.
- `iStart` at cycle t: `oClearAcc` = 1 and `oBusy` = 1 in t+1. `oReady` = 1 from t+2.
- Beat accepted at cycle a: array i lanes show the data with `oValid[i]` = 1 in cycle a+1+i.
- Last beat accepted at cycle L: `oReady` drops in L+1. `oDone` = 1 in L+ARRAY_NUM, the same cycle the last array shows its final beat. `oBusy` = 0 from L+ARRAY_NUM+1.
- `iLen` = 0: `oClearAcc` in t+1, `oDone` in t+2, and no `oValid`.
- A new `iStart` is accepted in the cycle after DONE at the earliest.

## Structure
- A shared package `pe_cube_pkg` holds:
  - FSM state encodings;
  - default DATA_W;
  - a lane-index helper (array i, block j → `j*ARRAY_NUM+i`), so the feeder and the cube agree on packing.
- Sub-module `skew_delay_line #(DEPTH, WIDTH)`: a zero-reset shift register carrying data and valid. It is instantiated per array with DEPTH = i, and DEPTH 0 is a wire.
- The FSM, counter and select logic live in the top level.

## Test plan
All scenarios use ARRAY_NUM = BLOCK_NUM = 3 and DATA_W = 8.
1. **Reset:** assert `iRst` asynchronously → all outputs 0 immediately; `oReady` 0. Release → IDLE, outputs 0.
2. **Basic pass:** `iLen`=2, mask=0, beats `iData1`={03,02,01}, {06,05,04} accepted at a, a+1 → `oClearAcc` once; array0 lanes 01 at a+1, 04 at a+2; array2 lanes 03 at a+3, 06 at a+4; `oDone` at a+4.
3. **Mask coverage:** mask bits per array = 3'b110, `iData1`=11, `iData2`=22 → block0 lanes 11 and blocks 1–2 lanes 22 (legacy pattern 1). Then mask 9'h1FF → all lanes 22.
4. **Bubble:** `iLen`=3 with `iValid` low for one mid-pass cycle → one zero/`oValid`=0 slot per array; three valid beats still delivered; `oDone` delayed by one cycle.
5. **Empty pass:** `iLen`=0 → `oClearAcc` at t+1, `oDone` at t+2, `oValid` never set.
6. **Interruptions:** `iRst` during STREAM → immediate IDLE with outputs 0; the next `iStart` runs a full clean pass. `iStart` pulsed during DRAIN → ignored, with no second `oClearAcc`.
